// File: rtl/daq_arbiter_if.sv
// DAQ producer/consumer bundle: per-producer req/grant/valid/end
// toward the arbiter, plus the merged output stream.
interface daq_arbiter_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]    daq_req;
    logic [NREQ-1:0]    daq_grant;
    logic [NREQ*32-1:0] daq_data;
    logic [NREQ-1:0]    daq_valid;
    logic [NREQ-1:0]    daq_end;
    logic [31:0]        out_data;
    logic               out_end;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  daq_req, daq_data, daq_valid, daq_end, out_ready,
        output daq_grant, out_data, out_end, out_valid
    );

    modport master (
        output daq_req, daq_data, daq_valid, daq_end, out_ready,
        input  daq_grant, out_data, out_end, out_valid
    );
endinterface

// File: rtl/daq_arbiter.sv
// Round-robin packet arbiter: serialises whole producer packets into
// a word FIFO so words of different packets never interleave.
module daq_arbiter #(
    parameter int NREQ        = 4,
    parameter int FIFO_DEPTH  = 64,
    parameter int MAX_PKT     = 8,
    parameter int PKT_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    daq_arbiter_if.slave                bus,
    output logic [2:0]                  err,
    input  logic                        clr_err,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int OW = $clog2(NREQ);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(MAX_PKT + 1);
    localparam int TW = $clog2(PKT_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GRANT, RECV} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [WW-1:0]   words_q, words_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [2:0]      err_q, err_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [32:0]     mem_q [FIFO_DEPTH];

    logic [OW-1:0]   pick;
    logic            found;
    logic            wr_en, rd_en;
    logic [32:0]     wr_word;
    logic [NREQ-1:0] own_mask;
    logic [31:0]     own_data;
    logic            own_valid, own_end;
    logic            has_room, pkt_full, last_slot, stray;

    assign own_mask  = NREQ'(1) << owner_q;
    assign own_valid = bus.daq_valid[owner_q];
    assign own_end   = bus.daq_end[owner_q];
    assign own_data  = bus.daq_data[32*owner_q +: 32];
    assign has_room  = int'(cnt_q) + MAX_PKT <= FIFO_DEPTH;
    assign pkt_full  = int'(words_q) >= MAX_PKT;
    assign last_slot = int'(words_q) == MAX_PKT - 1;
    assign stray     = |(bus.daq_valid &
                         ~((state_q == RECV) ? own_mask : '0));

    // Search starts just after the previous owner.
    always_comb begin
        int idx;
        pick  = last_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!found && bus.daq_req[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        words_d = words_q;
        tmo_d   = tmo_q;
        wr_en   = 1'b0;
        wr_word = '0;
        err_d   = clr_err ? 3'b000 : err_q;
        if (stray) err_d[2] = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (found && has_room) begin
                    owner_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                tmo_d   = TW'(PKT_TIMEOUT);
                words_d = '0;
                state_d = RECV;
            end
            RECV: begin
                if (own_valid) begin
                    if (!pkt_full) begin
                        wr_en   = 1'b1;
                        wr_word = {own_end || last_slot, own_data};
                        words_d = words_q + WW'(1);
                        tmo_d   = TW'(PKT_TIMEOUT);
                    end else begin
                        err_d[0] = 1'b1;
                    end
                    if (own_end) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end else if (tmo_q == '0) begin
                    state_d  = IDLE;
                    last_d   = owner_q;
                    err_d[1] = 1'b1;
                    // A full packet already carries a forced end.
                    if (words_q != '0 && !pkt_full) begin
                        wr_en   = 1'b1;
                        wr_word = {1'b1,
                                   32'hDEAD_0000 | 32'(owner_q)};
                    end
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en  = (cnt_q != '0) && bus.out_ready;
        wptr_d = wr_en ? wptr_q + AW'(1) : wptr_q;
        rptr_d = rd_en ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            words_q <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            words_q <= words_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= wr_word;
    end

    assign bus.daq_grant = (state_q == GRANT) ? own_mask : '0;
    assign bus.out_valid = cnt_q != '0;
    assign {bus.out_end, bus.out_data} =
        (cnt_q != '0) ? mem_q[rptr_q] : 33'd0;
    assign err   = err_q;
    assign level = cnt_q;
endmodule

// File: tb/tb_daq_arbiter.sv
// Bench for daq_arbiter: packet table plus hand sequences for
// reservation, round robin, timeout, stray words and reset.
module tb_daq_arbiter;
    localparam int NREQ = 4;
    localparam int FD   = 64;
    localparam int MP   = 8;
    localparam int TO   = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        err;
    logic              clr_err;
    logic [$clog2(FD):0] level;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];
    logic [32:0] e;

    typedef struct {
        int          src;
        int          n;
        logic [31:0] base;
        logic [31:0] step;
        logic [2:0]  err;
    } vec_t;
    vec_t vt[4];

    always #5 clk = ~clk;

    daq_arbiter_if #(.NREQ(NREQ)) ifc ();

    daq_arbiter #(
        .NREQ(NREQ), .FIFO_DEPTH(FD),
        .MAX_PKT(MP), .PKT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc),
        .err(err), .clr_err(clr_err), .level(level)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int src, output int n);
        n = 0;
        while (ifc.daq_grant == '0 && n < 40) begin
            tick();
            n++;
        end
        chk("grant", 64'(ifc.daq_grant), 64'(1) << src);
        ifc.daq_req[src] = 1'b0;
        tick();
        chk("grant_pulse", 64'(ifc.daq_grant), 0);
    endtask

    task automatic send_word(input int src, input int idx,
                             input logic [31:0] d, input logic last);
        ifc.daq_valid = '0;
        ifc.daq_end = '0;
        ifc.daq_valid[src] = 1'b1;
        ifc.daq_end[src] = last;
        ifc.daq_data[32*src +: 32] = d;
        if (idx < MP) exp_q.push_back({last || idx == MP - 1, d});
        tick();
        ifc.daq_valid = '0;
        ifc.daq_end = '0;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((exp_q.size() != 0 || level != 0) && t < 300) begin
            tick();
            t++;
        end
        chk({nm, "_sb_left"}, 64'(exp_q.size()), 0);
        chk({nm, "_level"}, 64'(level), 0);
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err", 64'(err), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra act=%h exp=none",
                         {ifc.out_end, ifc.out_data});
            end else begin
                e = exp_q.pop_front();
                chk("sb_word", 64'({ifc.out_end, ifc.out_data}),
                    64'(e));
            end
        end
    end

    initial begin
        int n;
        logic gseen;
        vt[0] = '{1, 5,  32'h1000_0000, 32'h1, 3'b000};
        vt[1] = '{3, 8,  32'hA5A5_0000, 32'h3, 3'b000};
        vt[2] = '{2, 10, 32'h2200_0000, 32'h10, 3'b001};
        vt[3] = '{0, 1,  32'hFFFF_FFFF, 32'h0, 3'b000};

        ifc.daq_req = '0;
        ifc.daq_valid = '0;
        ifc.daq_end = '0;
        ifc.daq_data = '0;
        ifc.out_ready = 1'b1;
        clr_err = 1'b0;
        repeat (2) tick();
        chk("rst_grant", 64'(ifc.daq_grant), 0);
        chk("rst_out_valid", 64'(ifc.out_valid), 0);
        chk("rst_out_data", 64'(ifc.out_data), 0);
        chk("rst_out_end", 64'(ifc.out_end), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_level", 64'(level), 0);
        rst_n = 1'b1;
        tick();

        // Single producer, three words.
        ifc.daq_req[0] = 1'b1;
        wait_grant(0, n);
        chk("first_latency", 64'(n), 1);
        send_word(0, 0, 32'h3000_0001, 1'b0);
        chk("wr_to_valid", 64'(ifc.out_valid), 1);
        chk("head_data", 64'(ifc.out_data), 64'h3000_0001);
        send_word(0, 1, 32'h1122_3344, 1'b0);
        send_word(0, 2, 32'h5566_7788, 1'b1);
        drain("single");

        foreach (vt[r]) begin
            ifc.daq_req[vt[r].src] = 1'b1;
            wait_grant(vt[r].src, n);
            for (int i = 0; i < vt[r].n; i++)
                send_word(vt[r].src, i,
                          vt[r].base + vt[r].step * 32'(i),
                          i == vt[r].n - 1);
            drain($sformatf("vec%0d", r));
            chk($sformatf("vec%0d_err", r), 64'(err),
                64'(vt[r].err));
            clear_err();
        end

        // Round robin with last_owner = 1.
        ifc.daq_req[1] = 1'b1;
        wait_grant(1, n);
        send_word(1, 0, 32'h0101_0101, 1'b1);
        drain("rr_pre");
        ifc.daq_req[1] = 1'b1;
        ifc.daq_req[2] = 1'b1;
        wait_grant(2, n);
        send_word(2, 0, 32'h0202_0000, 1'b0);
        send_word(2, 1, 32'h0202_0001, 1'b1);
        wait_grant(1, n);
        chk("b2b_latency", 64'(n), 1);
        send_word(1, 0, 32'h0101_0000, 1'b0);
        send_word(1, 1, 32'h0101_0001, 1'b1);
        drain("rr");

        // FIFO reservation blocks a grant.
        ifc.out_ready = 1'b0;
        for (int p = 0; p < 7; p++) begin
            ifc.daq_req[0] = 1'b1;
            wait_grant(0, n);
            for (int i = 0; i < MP; i++)
                send_word(0, i, 32'hF000_0000 + 32'(p * 16 + i),
                          i == MP - 1);
        end
        ifc.daq_req[0] = 1'b1;
        wait_grant(0, n);
        send_word(0, 0, 32'hF0FF_0000, 1'b1);
        chk("fill_level", 64'(level), FD - MP + 1);
        ifc.daq_req[3] = 1'b1;
        gseen = 1'b0;
        repeat (10) begin
            tick();
            if (ifc.daq_grant != '0) gseen = 1'b1;
        end
        chk("resv_block", 64'(gseen), 0);
        chk("resv_level", 64'(level), FD - MP + 1);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("resv_pop", 64'(level), FD - MP);
        wait_grant(3, n);
        chk("resv_grant_lat", 64'(n), 1);
        send_word(3, 0, 32'h3333_0003, 1'b1);
        ifc.out_ready = 1'b1;
        drain("resv");

        // Timeout after one word.
        ifc.daq_req[1] = 1'b1;
        wait_grant(1, n);
        send_word(1, 0, 32'h7777_0077, 1'b0);
        exp_q.push_back({1'b1, 32'hDEAD_0001});
        repeat (TO) tick();
        chk("tmo_early", 64'(err), 0);
        tick();
        chk("tmo_err", 64'(err), 3'b010);
        ifc.daq_req[2] = 1'b1;
        wait_grant(2, n);
        chk("tmo_idle", 64'(n), 1);
        send_word(2, 0, 32'h2222_0002, 1'b1);
        drain("tmo");
        clear_err();

        // Stray words, and clear racing a new error.
        ifc.daq_valid[2] = 1'b1;
        tick();
        ifc.daq_valid = '0;
        chk("stray_err", 64'(err), 3'b100);
        chk("stray_drop", 64'(level), 0);
        clr_err = 1'b1;
        ifc.daq_valid[1] = 1'b1;
        tick();
        ifc.daq_valid = '0;
        clr_err = 1'b0;
        chk("clr_vs_err", 64'(err), 3'b100);
        clear_err();

        // Asynchronous reset during a packet.
        ifc.out_ready = 1'b0;
        ifc.daq_req[0] = 1'b1;
        wait_grant(0, n);
        send_word(0, 0, 32'hAAAA_0000, 1'b0);
        send_word(0, 1, 32'hAAAA_0001, 1'b0);
        chk("pre_rst_level", 64'(level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ifc.out_valid), 0);
        chk("arst_level", 64'(level), 0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        ifc.daq_req[3] = 1'b1;
        wait_grant(3, n);
        send_word(3, 0, 32'hC0DE_0003, 1'b1);
        drain("post_rst");
        chk("post_rst_err", 64'(err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/daq_arbiter.md
# daq_arbiter

Collects DAQ packets from up to NREQ producers (DRO readers, encoders, etc.) over the shared req/grant/valid/end handshake, serialises them one packet at a time through a round-robin arbiter into a word FIFO, and presents the merged stream to the DAQ transport stage. It sits directly downstream of every DAQ producer and guarantees that words of different packets never interleave.

## Interface
Parameters:
- NREQ, 4: number of producers (2..8).
- FIFO_DEPTH, 64: FIFO words, power of two, ≥ MAX_PKT.
- MAX_PKT, 8: max words per packet; also the free-space reservation required before a grant.
- PKT_TIMEOUT, 255: cycles after grant without a word before the packet is aborted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- daq_req  in  NREQ  per-producer request, level, held until granted.
- daq_grant  out  NREQ  one-hot grant pulse, one cycle.
- daq_data  in  NREQ*32  producer words; slice i = [32*i+31:32*i].
- daq_valid  in  NREQ  per-producer word strobe.
- daq_end  in  NREQ  per-producer last-word marker, qualified by daq_valid.
- out_data  out  32  FIFO head word.
- out_end  out  1  head word is last of its packet.
- out_valid  out  1  head word present.
- out_ready  in  1  consumer accepts head when out_valid && out_ready.
- err  out  3  sticky flags: [0] packet too long, [1] timeout, [2] stray word.
- clr_err  in  1  synchronous clear of err.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- States: IDLE, GRANT, RECV.
- IDLE: if any daq_req bit set and FIFO_DEPTH − level ≥ MAX_PKT, select the requester by round robin starting at last_owner+1 (mod NREQ), register owner, go GRANT. last_owner resets to NREQ−1 (source 0 wins first).
- GRANT: daq_grant[owner] = 1 for exactly this cycle; load timeout counter = PKT_TIMEOUT; go RECV.
- RECV: each cycle with daq_valid[owner]: if words_in_pkt < MAX_PKT write {daq_end[owner], word} to FIFO, increment words_in_pkt, reload timeout counter; otherwise drop the word and set err[0]. The final kept word (the MAX_PKT-th) is written with end=1 forced if daq_end is absent. On daq_end[owner] go IDLE, last_owner ← owner.
- Timeout: the counter decrements on cycles without an owner word; at 0 go IDLE. If ≥1 word was written, the last written word's end bit is not rewritable, so a single word {end=1, data=32'hDEAD_0000 | owner} is appended as terminator (space is guaranteed by the reservation). Set err[1].
- daq_valid from a non-owner, or from anyone in IDLE/GRANT: word dropped, err[2] set.
- Packets in the FIFO are contiguous; a new grant is issued only after the previous packet is closed.
- clr_err clears err; a simultaneous new error event wins (flag stays set).

## Timing
- Reset values: daq_grant 0, out_valid 0, out_data 0, out_end 0, err 0, level 0, state IDLE.
- Request to grant: req seen at edge n → GRANT state from edge n+1 → daq_grant high cycle n+1.
- Back-to-back packets: end in cycle m → IDLE at m+1 → next grant pulse at m+2 earliest.
- FIFO write-to-out_valid latency 1 cycle; out_data/out_end stable while out_valid && !out_ready.
- Simultaneous read and write: level unchanged; full/empty cannot occur mid-packet because of the reservation.
- A daq_req still asserted in the grant cycle is not regranted until the next arbitration in IDLE.
- rst_n asserted mid-packet: FIFO emptied, packet lost, all outputs return to reset values immediately (asynchronous).

## Test plan
- Single producer 0: req, then 3 words 0x30000001, 0x11223344, 0x55667788 (last with end) → grant[0] one cycle, out stream of the 3 words, out_end on the third only, level back to 0.
- Producers 1 and 2 request together, last_owner=1 → grant order 2, then 1; no interleaving of words.
- FIFO held with out_ready=0 until level = FIFO_DEPTH−MAX_PKT+1 → pending request not granted; release one word → grant issued.
- Producer sends MAX_PKT+2 words → first MAX_PKT stored, the MAX_PKT-th with end=1, err[0]=1.
- Grant then 1 word and silence for PKT_TIMEOUT+1 cycles → terminator 0xDEAD0000|owner with end=1 appended, err[1]=1, state IDLE; clr_err → err=0.
- rst_n low during RECV with 2 words queued → out_valid=0, level=0 immediately; post-reset request from source 3 granted normally.
